// File: rtl/cam_pkg.sv
// Shared types and helpers for the DVP camera capture path.
package cam_pkg;

  localparam int DVP_W = 8;
  localparam int PIX_W = 16;
  localparam int CNT_W = 12;

  typedef enum logic [1:0] {SKIP, WAIT, CAP, DROP} cap_state_t;

  function automatic logic [PIX_W-1:0] pack_pair(input logic [DVP_W-1:0] first,
                                                 input logic [DVP_W-1:0] second,
                                                 input logic             hi_first);
    return hi_first ? {first, second} : {second, first};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// DVP input register stage with registered vsync/href edge pulses aligned to the delayed bus.
module dvp_sync_edge
  import cam_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             href,
  input  logic [DVP_W-1:0] data,
  output logic             href_q,
  output logic [DVP_W-1:0] data_q,
  output logic             vs_rise,
  output logic             vs_fall,
  output logic             href_fall
);

  logic             vs_s1;
  logic             href_s1;
  logic [DVP_W-1:0] data_s1;
  logic             vs_q;

  // Pulses are registered alongside href_q/data_q so they line up with the bytes they frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1     <= 1'b0;
      href_s1   <= 1'b0;
      data_s1   <= '0;
      vs_q      <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= '0;
      vs_rise   <= 1'b0;
      vs_fall   <= 1'b0;
      href_fall <= 1'b0;
    end else begin
      vs_s1     <= vsync;
      href_s1   <= href;
      data_s1   <= data;
      vs_q      <= vs_s1;
      href_q    <= href_s1;
      data_q    <= data_s1;
      vs_rise   <= vs_s1 & ~vs_q;
      vs_fall   <= ~vs_s1 & vs_q;
      href_fall <= ~href_s1 & href_q;
    end
  end

endmodule

// File: rtl/cmos_capture_pack.sv
// DVP camera capture: frame skipping/dropping FSM, RGB565 byte-pair packer and FIFO write port.
module cmos_capture_pack
  import cam_pkg::*;
#(
  parameter int SKIP_FRAMES = 10,
  parameter int H_PIXELS    = 1280,
  parameter int V_LINES     = 720,
  parameter int HI_FIRST    = 1
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [DVP_W-1:0] cam_data,
  input  logic             fifo_full,
  input  logic             fifo_afull,
  input  logic             clr_status,
  output logic             wr_en,
  output logic [PIX_W-1:0] wr_data,
  output logic             frame_start,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt,
  output logic             overflow_err,
  output logic             size_err
);

  localparam logic [15:0]      SKIP_N = 16'(SKIP_FRAMES);
  localparam logic [CNT_W-1:0] H_N    = CNT_W'(H_PIXELS);
  localparam logic [CNT_W-1:0] V_N    = CNT_W'(V_LINES);

  logic             href_q;
  logic [DVP_W-1:0] data_q;
  logic             vs_rise;
  logic             vs_fall;
  logic             href_fall;

  dvp_sync_edge u_sync (
    .clk       (wr_clk),
    .rst_n     (wr_rst_n),
    .vsync     (cam_vsync),
    .href      (cam_href),
    .data      (cam_data),
    .href_q    (href_q),
    .data_q    (data_q),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .href_fall (href_fall)
  );

  cap_state_t       state;
  logic [15:0]      skip_cnt;
  logic             phase;
  logic [DVP_W-1:0] first_byte;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;

  logic [CNT_W-1:0] line_after;
  logic [15:0]      drop_inc;
  logic             ovf_now;
  logic             frame_begin;

  always_comb begin
    line_after  = href_fall ? sat_inc(line_cnt) : line_cnt;
    drop_inc    = (drop_cnt == '1) ? drop_cnt : drop_cnt + 16'd1;
    ovf_now     = href_q & phase & fifo_full;
    frame_begin = vs_fall & ((state == WAIT) | (state == CAP));
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state        <= SKIP;
      skip_cnt     <= '0;
      phase        <= 1'b0;
      first_byte   <= '0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      wr_en        <= 1'b0;
      wr_data      <= '0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      drop_cnt     <= '0;
      overflow_err <= 1'b0;
      size_err     <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      // Clear first so any error set later in this cycle takes priority.
      if (clr_status) begin
        overflow_err <= 1'b0;
        size_err     <= 1'b0;
      end

      case (state)
        SKIP: begin
          if (SKIP_FRAMES == 0) begin
            state <= WAIT;
          end else if (vs_fall) begin
            skip_cnt <= skip_cnt + 16'd1;
            if (skip_cnt + 16'd1 >= SKIP_N) state <= WAIT;
          end
        end
        WAIT: ;
        CAP: begin
          if (vs_fall) begin
            size_err <= 1'b1;
          end else begin
            if (href_q) begin
              if (!phase) begin
                first_byte <= data_q;
                phase      <= 1'b1;
              end else if (fifo_full) begin
                overflow_err <= 1'b1;
                drop_cnt     <= drop_inc;
                state        <= DROP;
              end else begin
                wr_en   <= 1'b1;
                wr_data <= pack_pair(first_byte, data_q, HI_FIRST != 0);
                pix_cnt <= sat_inc(pix_cnt);
                phase   <= 1'b0;
              end
            end
            // Line end is folded into line_after so a coincident frame end sees the final count.
            if (href_fall) begin
              line_cnt <= line_after;
              if (pix_cnt != H_N || phase) size_err <= 1'b1;
              pix_cnt <= '0;
              phase   <= 1'b0;
            end
            if (vs_rise && !ovf_now) begin
              if (line_after != V_N) size_err <= 1'b1;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
              state      <= WAIT;
            end
          end
        end
        DROP: begin
          if (vs_rise) state <= WAIT;
        end
      endcase

      // A fall in CAP truncates the running frame and restarts under the same rules as WAIT.
      if (frame_begin) begin
        if (fifo_afull) begin
          drop_cnt <= drop_inc;
          state    <= DROP;
        end else begin
          frame_start <= 1'b1;
          pix_cnt     <= '0;
          line_cnt    <= '0;
          phase       <= 1'b0;
          state       <= CAP;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_capture_pack.sv
// Directed bench for cmos_capture_pack: two instances differing only in byte order.
module tb_cmos_capture_pack;

  logic        wr_clk     = 1'b0;
  logic        wr_rst_n   = 1'b0;
  logic        cam_vsync  = 1'b1;
  logic        cam_href   = 1'b0;
  logic [7:0]  cam_data   = '0;
  logic        fifo_full  = 1'b0;
  logic        fifo_afull = 1'b0;
  logic        clr_status = 1'b0;

  logic        wr_en, frame_start, frame_done, overflow_err, size_err;
  logic [15:0] wr_data, frame_cnt, drop_cnt;
  logic        wr_en_b, frame_start_b, frame_done_b, overflow_err_b, size_err_b;
  logic [15:0] wr_data_b, frame_cnt_b, drop_cnt_b;

  cmos_capture_pack #(.SKIP_FRAMES(2), .H_PIXELS(4), .V_LINES(4), .HI_FIRST(1)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .fifo_full(fifo_full), .fifo_afull(fifo_afull), .clr_status(clr_status),
    .wr_en(wr_en), .wr_data(wr_data), .frame_start(frame_start), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .overflow_err(overflow_err), .size_err(size_err)
  );

  cmos_capture_pack #(.SKIP_FRAMES(2), .H_PIXELS(4), .V_LINES(4), .HI_FIRST(0)) dut_b (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .fifo_full(fifo_full), .fifo_afull(fifo_afull), .clr_status(clr_status),
    .wr_en(wr_en_b), .wr_data(wr_data_b), .frame_start(frame_start_b), .frame_done(frame_done_b),
    .frame_cnt(frame_cnt_b), .drop_cnt(drop_cnt_b), .overflow_err(overflow_err_b),
    .size_err(size_err_b)
  );

  always #5 wr_clk = ~wr_clk;

  int cyc = 0;
  always @(posedge wr_clk) cyc <= cyc + 1;

  int          wr_cnt, fs_cnt, fd_cnt, first_edge, sb_edge;
  logic [15:0] first_a, first_b, last_a;

  always @(negedge wr_clk) begin
    if (wr_en) begin
      if (wr_cnt == 0) begin
        first_a    = wr_data;
        first_b    = wr_data_b;
        first_edge = cyc;
      end
      last_a = wr_data;
      wr_cnt++;
    end
    if (frame_start) fs_cnt++;
    if (frame_done)  fd_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic h, input logic [7:0] d);
    cam_vsync = v;
    cam_href  = h;
    cam_data  = d;
    tick();
  endtask

  function automatic logic [7:0] bval(input int l, input int i, input logic [7:0] seed);
    if (l == 0 && i == 0) return 8'hF8;
    if (l == 0 && i == 1) return 8'h1F;
    return seed + 8'(l * 8 + i);
  endfunction

  // Frame from vsync fall to vsync rise; short_line gets 7 bytes, full_line raises fifo_full.
  task automatic frame(input int nl, input int short_line, input int full_line,
                       input logic [7:0] seed);
    int nb;
    wr_cnt = 0;
    fs_cnt = 0;
    fd_cnt = 0;
    repeat (4) drv(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < nl; l++) begin
      if (l == full_line) fifo_full = 1'b1;
      nb = (l == short_line) ? 7 : 8;
      for (int i = 0; i < nb; i++) begin
        if (l == 0 && i == 1) sb_edge = cyc + 1;
        drv(1'b0, 1'b1, bval(l, i, seed));
      end
      repeat (3) drv(1'b0, 1'b0, 8'h00);
    end
    repeat (5) drv(1'b1, 1'b0, 8'h00);
    fifo_full = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_errs", {overflow_err, size_err, frame_start, frame_done}, 0);
    wr_rst_n = 1'b1;
    tick();

    frame(4, -1, -1, 8'h10);
    check("skip0_writes", wr_cnt, 0);
    frame(4, -1, -1, 8'h20);
    check("skip1_writes", wr_cnt, 0);
    check("skip1_starts", fs_cnt, 0);
    frame(4, -1, -1, 8'h40);
    check("cap_writes", wr_cnt, 16);
    check("cap_frame_cnt", frame_cnt, 1);
    check("cap_frame_cnt_b", frame_cnt_b, 1);
    check("cap_starts", fs_cnt, 1);
    check("cap_dones", fd_cnt, 1);
    check("cap_errs", {overflow_err, size_err}, 0);
    check("pack_hi_first", first_a, 32'hF81F);
    check("pack_lo_first", first_b, 32'h1FF8);
    check("pack_latency", first_edge - sb_edge, 2);
    check("cap_last_data", last_a, 32'h5E5F);

    fifo_afull = 1'b1;
    frame(4, -1, -1, 8'h60);
    fifo_afull = 1'b0;
    check("afull_writes", wr_cnt, 0);
    check("afull_drop_cnt", drop_cnt, 1);
    check("afull_starts", fs_cnt, 0);
    check("afull_frame_cnt", frame_cnt, 1);
    frame(4, -1, -1, 8'h80);
    check("after_drop_writes", wr_cnt, 16);
    check("after_drop_frame_cnt", frame_cnt, 2);

    frame(4, -1, 1, 8'hA0);
    check("full_writes", wr_cnt, 4);
    check("full_last_data", last_a, 32'hA6A7);
    check("full_ovf", overflow_err, 1);
    check("full_drop_cnt", drop_cnt, 2);
    check("full_frame_cnt", frame_cnt, 2);
    check("full_dones", fd_cnt, 0);
    check("full_size_err", size_err, 0);
    pulse_clr();
    check("clr_ovf", overflow_err, 0);

    frame(4, 0, -1, 8'hC0);
    check("odd_writes", wr_cnt, 15);
    check("odd_size_err", size_err, 1);
    check("odd_frame_cnt", frame_cnt, 3);
    check("odd_ovf", overflow_err, 0);
    pulse_clr();
    check("clr_size", size_err, 0);
    frame(3, -1, -1, 8'hE0);
    check("short_writes", wr_cnt, 12);
    check("short_size_err", size_err, 1);
    check("short_frame_cnt", frame_cnt, 4);
    check("short_dones", fd_cnt, 1);

    repeat (4) drv(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) drv(1'b0, 1'b1, bval(1, i, 8'h00));
    check("pre_rst_wr_en", wr_en, 1);
    wr_rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    check("midrst_errs", {overflow_err, size_err}, 0);
    cam_href = 1'b0;
    repeat (2) tick();
    wr_rst_n = 1'b1;
    repeat (2) drv(1'b0, 1'b0, 8'h00);
    repeat (4) drv(1'b1, 1'b0, 8'h00);
    frame(4, -1, -1, 8'h30);
    check("reskip0_writes", wr_cnt, 0);
    frame(4, -1, -1, 8'h50);
    check("reskip1_writes", wr_cnt, 0);
    frame(4, -1, -1, 8'h70);
    check("recap_writes", wr_cnt, 16);
    check("recap_frame_cnt", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
